hash_line_rx: RTL and testbench

HASH_LINE_RX -- requirements
Module: hash_line_rx

---
 rtl/hash_rx_pkg.sv | 17 +
 rtl/ascii_hex_decode.sv | 27 ++
 rtl/hash_line_rx.sv | 149 ++++++++++++++
 tb/tb_hash_line_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hash_rx_pkg.sv
// Shared types and constants for the hex hash line receiver.
package hash_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WAIT_EOL,
        S_HOLD,
        S_SKIP
    } state_t;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    localparam int unsigned NIBBLES_DEFAULT = 32;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII classifier: hex digit value, end-of-line, or neither.
module ascii_hex_decode
    import hash_rx_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       is_hex,
    output logic       is_eol,
    output logic [3:0] nib
);

    always_comb begin
        is_hex = 1'b0;
        nib    = '0;
        if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
            is_hex = 1'b1;
            nib    = byte_in[3:0];
        end else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
                     (byte_in >= 8'h61 && byte_in <= 8'h66)) begin
            // Letters A-F / a-f have low nibble 1..6, so +9 yields 10..15.
            is_hex = 1'b1;
            nib    = byte_in[3:0] + 4'd9;
        end
    end

    assign is_eol = (byte_in == CR) || (byte_in == LF);

endmodule

// File: rtl/hash_line_rx.sv
// Parses one line of NIBBLES hex digits terminated by CR/LF into a hash,
// then holds it until the consumer accepts it.
module hash_line_rx
    import hash_rx_pkg::*;
#(
    parameter int unsigned NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_error,
    output logic [4*NIBBLES-1:0] hash_out,
    output logic                 hash_valid,
    input  logic                 hash_ready,
    output logic                 parse_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [5:0] LAST = 6'(NIBBLES);

    logic       is_hex;
    logic       is_eol;
    logic [3:0] nib;

    ascii_hex_decode u_dec (
        .byte_in (rx_byte),
        .is_hex  (is_hex),
        .is_eol  (is_eol),
        .nib     (nib)
    );

    state_t               state_q,      state_d;
    logic [5:0]           cnt_q,        cnt_d;
    logic [4*NIBBLES-1:0] hash_q,       hash_d;
    logic                 hash_valid_q, hash_valid_d;
    logic                 parse_err_q,  parse_err_d;
    logic                 overrun_q,    overrun_d;
    logic                 busy_q,       busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hash_d      = hash_q;
        parse_err_d = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_error) begin
                    parse_err_d = 1'b1;
                    state_d     = S_SKIP;
                end else if (rx_valid) begin
                    if (is_hex) begin
                        hash_d      = '0;
                        hash_d[3:0] = nib;
                        cnt_d       = 6'd1;
                        state_d     = S_COLLECT;
                    end else if (!is_eol) begin
                        parse_err_d = 1'b1;
                        state_d     = S_SKIP;
                    end
                end
            end
            S_COLLECT: begin
                if (rx_error) begin
                    parse_err_d = 1'b1;
                    state_d     = S_SKIP;
                end else if (rx_valid) begin
                    if (is_hex) begin
                        hash_d = {hash_q[4*NIBBLES-5:0], nib};
                        cnt_d  = cnt_q + 6'd1;
                        if (cnt_q + 6'd1 == LAST) begin
                            state_d = S_WAIT_EOL;
                        end
                    end else if (is_eol) begin
                        parse_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        parse_err_d = 1'b1;
                        state_d     = S_SKIP;
                    end
                end
            end
            S_WAIT_EOL: begin
                if (rx_error) begin
                    parse_err_d = 1'b1;
                    state_d     = S_SKIP;
                end else if (rx_valid) begin
                    if (is_eol) begin
                        state_d = S_HOLD;
                    end else begin
                        parse_err_d = 1'b1;
                        state_d     = S_SKIP;
                    end
                end
            end
            S_HOLD: begin
                // Bytes cannot be buffered here; they are reported and lost.
                overrun_d = rx_valid | rx_error;
                if (hash_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_SKIP: begin
                if (rx_valid && is_eol) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_IDLE) begin
            cnt_d = '0;
        end
        hash_valid_d = (state_d == S_HOLD);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hash_q       <= '0;
            hash_valid_q <= 1'b0;
            parse_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hash_q       <= hash_d;
            hash_valid_q <= hash_valid_d;
            parse_err_q  <= parse_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign hash_out   = hash_q;
    assign hash_valid = hash_valid_q;
    assign parse_err  = parse_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_hash_line_rx.sv
// Directed bench for hash_line_rx: drives ASCII lines and checks the parsed hash and status pulses.
module tb_hash_line_rx;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         rx_error = 1'b0;
    logic [127:0] hash_out;
    logic         hash_valid;
    logic         hash_ready = 1'b0;
    logic         parse_err;
    logic         overrun;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int perr_cnt = 0;
    int ovr_cnt = 0;
    int hv_cnt = 0;
    logic hv_prev = 1'b0;

    localparam logic [127:0] H1 = 128'h9732ab100ad8d4a38dbbfe85bcdafde8;
    localparam logic [127:0] H2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] H3 = 128'hffffffff00000000a5a5a5a5c3c3c3c3;

    hash_line_rx #(.NIBBLES(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_error   (rx_error),
        .hash_out   (hash_out),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .parse_err  (parse_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (parse_err) perr_cnt++;
        if (overrun) ovr_cnt++;
        if (hash_valid && !hv_prev) hv_cnt++;
        hv_prev = hash_valid;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic accept();
        @(negedge clk);
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0;
    endtask

    initial begin
        int p0, o0, h0;
        logic [127:0] snap;

        // Reset values are forced asynchronously, before any clock edge.
        #1;
        check("rst_hash", hash_out, '0);
        check("rst_valid", 128'(hash_valid), 0);
        check("rst_busy", 128'(busy), 0);
        check("rst_perr", 128'(parse_err), 0);
        check("rst_ovr", 128'(overrun), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lowercase line with CR
        send_str("9732ab100ad8d4a38dbbfe85bcdafde");
        send_byte("8");
        check("l1_not_yet_valid", 128'(hash_valid), 0);
        send_byte(8'h0D);
        check("l1_valid", 128'(hash_valid), 1);
        check("l1_hash", hash_out, H1);
        accept();
        check("l1_valid_after_ack", 128'(hash_valid), 0);
        check("l1_busy_after_ack", 128'(busy), 0);
        check("l1_no_perr", 128'(perr_cnt), 0);

        // Mixed case with CR LF; LF arrives after the hash was taken
        p0 = perr_cnt; o0 = ovr_cnt;
        send_str("9732AB100AD8D4A38DBBFE85BCDAFDE8");
        send_byte(8'h0D);
        check("l2_valid", 128'(hash_valid), 1);
        check("l2_hash", hash_out, H1);
        accept();
        send_byte(8'h0A);
        send_byte(8'h0D);
        send_byte(8'h0A);
        check("l2_lf_busy", 128'(busy), 0);
        check("l2_lf_no_perr", 128'(perr_cnt - p0), 0);
        check("l2_lf_no_ovr", 128'(ovr_cnt - o0), 0);

        // Invalid character mid-line
        p0 = perr_cnt; h0 = hv_cnt;
        send_str("12");
        send_byte("G");
        check("bad_g_pulse", 128'(parse_err), 1);
        check("bad_g_skip_busy", 128'(busy), 1);
        send_byte("4");
        check("bad_g_single", 128'(parse_err), 0);
        send_byte(8'h0D);
        check("bad_g_idle", 128'(busy), 0);
        check("bad_g_perr_cnt", 128'(perr_cnt - p0), 1);
        check("bad_g_no_valid", 128'(hv_cnt - h0), 0);
        send_str("0123456789abcdefFEDCBA9876543210");
        send_byte(8'h0D);
        check("after_bad_valid", 128'(hash_valid), 1);
        check("after_bad_hash", hash_out, H2);
        accept();

        // 31 digits then CR
        p0 = perr_cnt; h0 = hv_cnt;
        send_str("0123456789abcdef0123456789abcde");
        send_byte(8'h0D);
        check("short_pulse", 128'(parse_err), 1);
        check("short_idle", 128'(busy), 0);
        check("short_hold_partial", hash_out, 128'h0123456789abcdef0123456789abcde);

        // 33 digits then CR
        send_str("0123456789abcdef0123456789abcdef");
        send_byte("0");
        check("long_pulse", 128'(parse_err), 1);
        check("long_skip_busy", 128'(busy), 1);
        send_byte(8'h0D);
        check("long_idle", 128'(busy), 0);
        check("len_perr_cnt", 128'(perr_cnt - p0), 2);
        check("len_no_valid", 128'(hv_cnt - h0), 0);

        // rx_error in collect, then ignored in skip
        p0 = perr_cnt;
        send_str("abc");
        @(negedge clk); rx_error = 1'b1;
        @(negedge clk); rx_error = 1'b0;
        check("rxerr_pulse", 128'(parse_err), 1);
        @(negedge clk); rx_error = 1'b1;
        @(negedge clk); rx_error = 1'b0;
        check("rxerr_skip_ignored", 128'(parse_err), 0);
        check("rxerr_still_skip", 128'(busy), 1);
        send_byte(8'h0A);
        check("rxerr_idle", 128'(busy), 0);
        check("rxerr_perr_cnt", 128'(perr_cnt - p0), 1);

        // Stalled consumer with bytes arriving during hold
        send_str("ffffffff00000000a5a5a5a5c3c3c3c3");
        send_byte(8'h0D);
        check("stall_valid", 128'(hash_valid), 1);
        o0 = ovr_cnt;
        snap = hash_out;
        for (int c = 0; c < 1000; c++) begin
            if (c % 200 == 100) send_byte("7");
            else @(negedge clk);
        end
        check("stall_ovr_cnt", 128'(ovr_cnt - o0), 5);
        check("stall_hash_stable", hash_out, snap);
        check("stall_hash_value", hash_out, H3);
        check("stall_still_valid", 128'(hash_valid), 1);
        @(negedge clk); rx_error = 1'b1;
        @(negedge clk); rx_error = 1'b0;
        check("hold_rxerr_ovr", 128'(overrun), 1);
        check("hold_rxerr_no_perr", 128'(parse_err), 0);
        // Byte arriving on the very cycle of the transfer
        @(negedge clk);
        hash_ready = 1'b1;
        rx_valid   = 1'b1;
        rx_byte    = "Z";
        @(negedge clk);
        hash_ready = 1'b0;
        rx_valid   = 1'b0;
        check("xfer_ovr", 128'(overrun), 1);
        check("xfer_valid_low", 128'(hash_valid), 0);
        check("xfer_idle", 128'(busy), 0);
        send_str("0123456789abcdefFEDCBA9876543210");
        send_byte(8'h0D);
        check("post_stall_hash", hash_out, H2);
        accept();

        // Reset mid-line
        h0 = hv_cnt;
        send_str("0123456789");
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        check("midrst_hash", hash_out, '0);
        check("midrst_busy", 128'(busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        send_str("ffffffff00000000a5a5a5a5c3c3c3c3");
        send_byte(8'h0D);
        check("midrst_hash_new", hash_out, H3);
        accept();
        repeat (3) @(negedge clk);
        check("midrst_one_valid", 128'(hv_cnt - h0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
